// File: rtl/vec_exec_sequencer_if.sv
// Decode/Execute to Execute/Memory handshake bundle for the 16-lane x 32-bit vector sequencer.
// The upstream/downstream environment uses master; the sequencer uses slave.
interface vec_exec_sequencer_if;
  logic              in_valid;
  logic              in_ready;
  logic [15:0][31:0] RD1E;
  logic [15:0][31:0] RD2E;
  logic [31:0]       ExtImmE;
  logic [2:0]        ALUControlE;
  logic              ALUSrcE;
  logic              v_s_e;
  logic [3:0]        WA3E;
  logic              RegWriteE;
  logic              out_valid;
  logic              out_ready;
  logic [15:0][31:0] ResultE;
  logic [3:0]        WA3_out;
  logic              RegWrite_out;
  logic [3:0]        FlagsOut;
  logic              busy;

  modport master (
    output in_valid, RD1E, RD2E, ExtImmE, ALUControlE, ALUSrcE, v_s_e, WA3E, RegWriteE, out_ready,
    input  in_ready, out_valid, ResultE, WA3_out, RegWrite_out, FlagsOut, busy
  );

  modport slave (
    input  in_valid, RD1E, RD2E, ExtImmE, ALUControlE, ALUSrcE, v_s_e, WA3E, RegWriteE, out_ready,
    output in_ready, out_valid, ResultE, WA3_out, RegWrite_out, FlagsOut, busy
  );
endinterface

// File: rtl/vec_exec_sequencer.sv
// Multi-cycle execute stage: one decoded op is folded over LPC physical ALU lanes per cycle,
// with the finished vector, tag and lane-0 flags held for a valid/ready handoff.
module vec_exec_sequencer #(
  parameter int LPC    = 4,
  parameter int NLANES = 16
) (
  input logic             CLK,
  input logic             RST,
  vec_exec_sequencer_if.slave io
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t                             state_q, state_d;
  logic [4:0]                         cnt_q, cnt_d;
  logic [NLANES-1:0][DATA_W-1:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]                         op_q, op_d;
  logic                               vs_q, vs_d;
  logic [3:0]                         wa_q, wa_d;
  logic                               rw_q, rw_d;
  logic [3:0]                         flags_q, flags_d;
  logic                               accept;
  logic                               last_beat;

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << b[4:0];
      3'b110:  return a >> b[4:0];
      default: return a * b;
    endcase
  endfunction

  // Carry on ADD is detected as result wrapping below operand A.
  function automatic logic [3:0] alu_flags(input logic [2:0] op,
                                           input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b,
                                           input logic [DATA_W-1:0] r);
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: begin
        c = (r < a);
        v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      3'b001: begin
        c = (a >= b);
        v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      default: ;
    endcase
    return {r[DATA_W-1], (r == '0), c, v};
  endfunction

  assign accept    = io.in_valid && (state_q == IDLE);
  assign last_beat = ((cnt_q + 5'(LPC)) == 5'(NLANES));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (!vs_q || last_beat) state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready     = (state_q == IDLE) && !RST;
    io.out_valid    = (state_q == DONE);
    io.busy         = (state_q != IDLE);
    io.ResultE      = res_q;
    io.WA3_out      = wa_q;
    io.RegWrite_out = rw_q;
    io.FlagsOut     = flags_q;
  end

  // Operand capture and the per-beat lane window.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    vs_d    = vs_q;
    wa_d    = wa_q;
    rw_d    = rw_q;
    res_d   = res_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_d     = io.RD1E;
      b_d     = io.ALUSrcE ? {NLANES{io.ExtImmE}} : io.RD2E;
      op_d    = io.ALUControlE;
      vs_d    = io.v_s_e;
      wa_d    = io.WA3E;
      rw_d    = io.RegWriteE;
      res_d   = '0;
      flags_d = '0;
      cnt_d   = '0;
    end else if (state_q == EXEC) begin
      for (int j = 0; j < LPC; j++) begin
        if (vs_q || (j == 0))
          res_d[cnt_q[3:0] + 4'(j)] = alu(op_q, a_q[cnt_q[3:0] + 4'(j)], b_q[cnt_q[3:0] + 4'(j)]);
      end
      if (cnt_q == '0)
        flags_d = alu_flags(op_q, a_q[0], b_q[0], alu(op_q, a_q[0], b_q[0]));
      cnt_d = cnt_q + 5'(LPC);
    end
  end

  // Operand registers are only consumed after an accept, so they carry no reset.
  always_ff @(posedge CLK) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
    vs_q <= vs_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      res_q   <= '0;
      wa_q    <= '0;
      rw_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wa_q    <= wa_d;
      rw_q    <= rw_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: doc/vec_exec_sequencer.md
Name: vec_exec_sequencer

Overview:
- Execute-stage consumer of the Decode/Execute pipeline register outputs for the 16-lane x 32-bit vector datapath.
- Accepts one decoded operation per handshake. Executes it over several cycles on LPC physical ALU lanes.
- While busy, drives backpressure (in_ready low) so the stage upstream stalls.
- Presents the completed result vector, write-back tag and flags to the Execute/Memory boundary with a valid/ready handshake.

Parameters:
- LPC, 4, ALU lanes processed per cycle; legal values 1, 2, 4, 8, 16 (must divide 16).
- NLANES, 16, vector lanes; fixed, not to be overridden.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decoded op present from the D/E register.
- in_ready  out  1  sequencer can accept; low = stall upstream.
- RD1E  in  16x32  operand A vector, lane 0 = scalar operand.
- RD2E  in  16x32  operand B vector.
- ExtImmE  in  32  extended immediate.
- ALUControlE  in  3  operation select.
- ALUSrcE  in  1  1 = operand B is ExtImmE broadcast to all lanes.
- v_s_e  in  1  1 = vector op, 0 = scalar op (lane 0 only).
- WA3E  in  4  destination register tag.
- RegWriteE  in  1  write-back enable.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- ResultE  out  16x32  result vector.
- WA3_out  out  4  captured WA3E.
- RegWrite_out  out  1  captured RegWriteE.
- FlagsOut  out  4  {N,Z,C,V} from lane 0.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, EXEC, DONE. in_ready = (state==IDLE) && !RST.
- Accept: in_valid && in_ready at a posedge. Captures RD1E, RD2E (or the ExtImm broadcast), ALUControlE, v_s_e, WA3E and RegWriteE into internal registers. Clears ResultE to 0. Sets cnt=0. Goes to EXEC.
- EXEC, vector: each cycle computes lanes cnt..cnt+LPC-1, writes them into ResultE, then cnt += LPC. After the beat where cnt+LPC==16: state goes to DONE and out_valid goes to 1.
- EXEC, scalar: computes lane 0 only in one beat. Lanes 1-15 stay 0. Goes to DONE.
- Latency from the accept edge to out_valid=1: 16/LPC cycles for vector ops, 1 cycle for scalar ops.
- DONE: out_valid=1. ResultE, WA3_out, RegWrite_out and FlagsOut are stable until out_valid && out_ready.
- On out_valid && out_ready: state goes to IDLE and out_valid goes to 0. in_ready rises in that same next cycle.
- No accept in the DONE cycle, so the minimum initiation interval is latency+1.
- ALU ops, all 32-bit modulo wrap:
  - 000 ADD
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL by B[4:0]
  - 110 SRL by B[4:0]
  - 111 MUL, low 32 bits of the unsigned product
- Flags: computed on lane 0, captured in lane 0's beat.
  - N = R[31]; Z = (R==0).
  - ADD: C = carry-out; V = signed overflow.
  - SUB: C = no-borrow (A>=B unsigned); V = signed overflow.
  - All other ops: C=0, V=0.
- Reset (asserted at any time, including mid-EXEC or DONE):
  - state=IDLE, cnt=0, out_valid=0, ResultE=0, WA3_out=0, RegWrite_out=0, FlagsOut=0, busy=0, in_ready=0 while asserted.
  - The in-flight op is discarded; no partial result is ever presented.
- Changes on in_valid or the input buses while not in IDLE are ignored.
- out_ready held high in DONE: 1-cycle DONE dwell.
- out_ready low: DONE is held indefinitely with the outputs frozen.

Test Plan:
- LPC=4, vector ADD, RD1 lane i = i, RD2 lane i = 100, accept at cycle 0, out_ready=1. Required: in_ready=0 in cycles 1-4; out_valid=1 in cycle 4; ResultE lane i = 100+i; FlagsOut=0000; in_ready=1 in cycle 5.
- Scalar SUB, A=5, B=7, v_s_e=0. Required: out_valid 1 cycle after accept; lane0=0xFFFFFFFE; lanes 1-15 = 0; FlagsOut N=1, Z=0, C=0, V=0.
- ALUSrcE=1, ExtImmE=4, vector SLL, RD1 all lanes 0x1. Required: every lane = 0x10. Lane-0 ADD of 0x7FFFFFFF + 1 (imm) gives V=1, N=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid. Required: outputs unchanged, in_valid pulses ignored, in_ready=0; one cycle after out_ready=1, out_valid=0 and in_ready=1.
- Reset mid-EXEC at cnt=8 (LPC=4). Required: all outputs 0 immediately (async); no out_valid after release; the next accepted op completes normally.
- LPC=1 and LPC=16 builds, vector XOR 0xFFFFFFFF ^ 0x0F0F0F0F. Required: all lanes 0xF0F0F0F0; latency 16 and 1 cycles respectively.
